// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: z = x - y using one full-adder cell fed with x, ~y
// and a carry register preset to 1, one bit per clock, LSB first.
module serial_subtractor #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic         bout
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  xs_q, xs_d;
    logic [N-1:0]  ys_q, ys_d;
    logic [N-1:0]  rs_q, rs_d;
    logic [N-1:0]  z_q, z_d;
    logic          carry_q, carry_d;
    logic          bout_q, bout_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          sum_bit;
    logic          carry_nxt;
    logic          accept;
    logic          last_edge;
    logic [N-1:0]  rs_shift;

    // Full-adder cell on the current LSBs of the operand shift registers.
    always_comb begin
        sum_bit   = xs_q[0] ^ ys_q[0] ^ carry_q;
        carry_nxt = (xs_q[0] & ys_q[0]) | (xs_q[0] & carry_q) | (ys_q[0] & carry_q);
        accept    = (state_q == IDLE) && start;
        last_edge = (state_q == RUN) && (cnt_q == LAST);
    end

    // Result register fills from the MSB side so the LSB lands at bit 0 after N shifts.
    generate
        if (N == 1) begin : g_rs_one
            assign rs_shift = sum_bit;
        end else begin : g_rs_many
            assign rs_shift = {sum_bit, rs_q[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            rs_q    <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            z_q     <= z_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        z_d     = z_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (accept) begin
            xs_d    = x;
            ys_d    = ~y;
            carry_d = 1'b1;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            xs_d    = xs_q >> 1;
            ys_d    = ys_q >> 1;
            rs_d    = rs_shift;
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CW'(1);
            // A final carry of 0 means the subtraction needed a borrow.
            if (last_edge) begin
                z_d    = rs_shift;
                bout_d = ~carry_nxt;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        z    = z_q;
        bout = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed N=3 vectors, exhaustive N=3 sweep
// and a random N=8 run, with result checking decoupled into monitor processes.
module tb_serial_subtractor;
    localparam int N  = 3;
    localparam int N8 = 8;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [N-1:0]  x, y;
    logic          busy, done, bout;
    logic [N-1:0]  z;

    logic          start8;
    logic [N8-1:0] x8, y8;
    logic          busy8, done8, bout8;
    logic [N8-1:0] z8;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [N:0]  exp_q[$];
    logic [N8:0] exp8_q[$];

    serial_subtractor #(.N(N)) dut (
        .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .z(z), .bout(bout)
    );

    serial_subtractor #(.N(N8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .z(z8), .bout(bout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       done_prev = 1'b0;
    logic [N:0] got3, want3;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            checks++;
            got3 = {bout, z};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got bout=%0d z=%0d required no done", bout, z);
            end else begin
                want3 = exp_q.pop_front();
                if (got3 !== want3) begin
                    errors++;
                    $display("FAIL result3 got bout=%0d z=%0d required bout=%0d z=%0d",
                             got3[N], got3[N-1:0], want3[N], want3[N-1:0]);
                end
            end
            checks++;
            if (done_prev === 1'b1) begin
                errors++;
                $display("FAIL done_width3 got done high 2+ cycles required 1 cycle");
            end
        end
        done_prev = done;
    end

    logic        done8_prev = 1'b0;
    logic [N8:0] got8, want8;
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checks++;
            got8 = {bout8, z8};
            if (exp8_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done8 got bout=%0d z=%0d required no done", bout8, z8);
            end else begin
                want8 = exp8_q.pop_front();
                if (got8 !== want8) begin
                    errors++;
                    $display("FAIL result8 got bout=%0d z=%0d required bout=%0d z=%0d",
                             got8[N8], got8[N8-1:0], want8[N8], want8[N8-1:0]);
                end
            end
            checks++;
            if (done8_prev === 1'b1) begin
                errors++;
                $display("FAIL done_width8 got done high 2+ cycles required 1 cycle");
            end
        end
        done8_prev = done8;
    end

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0b required %0b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, want);
        end
    endtask

    // Issues one operation from an idle FSM and returns at the negedge of its done cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] ez, input logic eb);
        int         lat;
        int         busy_cnt;
        logic       held;
        logic       busy_at_done;
        logic [N:0] prev;
        exp_q.push_back({eb, ez});
        start = 1'b1;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = N'($urandom_range(0, (1 << N) - 1));
        y = N'($urandom_range(0, (1 << N) - 1));
        prev = {bout, z};
        lat = 0;
        busy_cnt = 0;
        held = 1'b1;
        busy_at_done = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                busy_at_done = busy;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if ({bout, z} !== prev) held = 1'b0;
        end
        check_int("latency", lat, N + 1);
        check_int("busy_cycles", busy_cnt, N);
        check1("result_held", held, 1'b1);
        check1("busy_in_done_cycle", busy_at_done, 1'b0);
    endtask

    task automatic run8(input logic [N8-1:0] a, input logic [N8-1:0] b);
        int lat;
        exp8_q.push_back({a < b, N8'(a - b)});
        start8 = 1'b1;
        x8 = a;
        y8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        x8 = ~a;
        y8 = ~b;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done8 === 1'b1) break;
        end
        check_int("latency8", lat, N8 + 1);
    endtask

    initial begin
        int            cnt0;
        logic [N-1:0]  ez;
        logic [N8-1:0] ra, rb;

        resetn = 1'b0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        start8 = 1'b0;
        x8     = '0;
        y8     = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_bout", bout, 1'b0);
        check_int("reset_z", int'(z), 0);

        run_op(3'd5, 3'd3, 3'b010, 1'b0);
        run_op(3'd3, 3'd5, 3'b110, 1'b1);
        run_op(3'd0, 3'd7, 3'b001, 1'b1);
        run_op(3'd7, 3'd7, 3'b000, 1'b0);
        // Started inside the done cycle of the previous operation.
        run_op(3'd4, 3'd2, 3'b010, 1'b0);
        @(posedge clk);
        #1;

        // Start pulse and operand changes during RUN must be ignored.
        cnt0 = done_count;
        exp_q.push_back({1'b0, 3'd5});
        start = 1'b1;
        x = 3'd6;
        y = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        x = 3'd0;
        y = 3'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_int("ignored_start_done_count", done_count - cnt0, 1);

        // Reset in the second RUN cycle aborts without a done.
        cnt0 = done_count;
        start = 1'b1;
        x = 3'd6;
        y = 3'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_bout", bout, 1'b0);
        check_int("abort_z", int'(z), 0);
        repeat (6) @(posedge clk);
        #1;
        check_int("abort_no_done", done_count - cnt0, 0);
        run_op(3'd2, 3'd1, 3'd1, 1'b0);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                ez = N'(a - b);
                run_op(N'(a), N'(b), ez, a < b);
            end
        end

        run8(8'd0, 8'd0);
        run8(8'd255, 8'd0);
        run8(8'd0, 8'd255);
        run8(8'd128, 8'd127);
        for (int i = 0; i < 24; i++) begin
            ra = N8'($urandom_range(0, 255));
            rb = N8'($urandom_range(0, 255));
            run8(ra, rb);
        end

        repeat (4) @(posedge clk);
        #1;
        check_int("exp_q_drained", exp_q.size(), 0);
        check_int("exp8_q_drained", exp8_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor, the inverse operation to the team's ripple-carry adder datapath.
- Computes z = x − y with a single full-adder cell. The cell adds x, ~y and a registered carry, one bit per clock, LSB first.
- The carry register is initialised to 1, which gives the two's-complement subtraction.
- Used where the subtract path must be area-minimal; a start/busy/done handshake connects it to the ALU control FSM.

Parameters:
- N, 3, operand width in bits (N ≥ 1). The bit counter width is clog2(N+1).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- resetn  input  1  synchronous, active-low reset, sampled on rising clk
- start  input  1  request; sampled only when the FSM is IDLE
- x  input  N  minuend, unsigned; sampled on the accepted-start edge only
- y  input  N  subtrahend, unsigned; sampled on the accepted-start edge only
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: z and bout are newly valid
- z  output  N  difference x − y mod 2^N; held until the next completion
- bout  output  1  borrow out: 1 iff x < y (unsigned); held with z

Behaviour:
- Reset (resetn=0 at a rising edge): FSM=IDLE, busy=0, done=0, z=0, bout=0, counter=0, shift regs=0, carry=0.
  - Applies mid-operation: the operation is aborted and no done is produced.
- FSM states:
  - IDLE:
    - busy=0.
    - If start=1: latch x into XS and ~y into YS, set carry=1, counter=0, go to RUN.
    - If start=0: remain in IDLE.
  - RUN, each edge:
    - s = XS[0] ^ YS[0] ^ carry.
    - carry <= majority(XS[0], YS[0], carry).
    - Shift XS and YS right by 1; shift s into the MSB of result shift register RS.
    - Increment counter.
    - On the edge where counter reaches N−1 (the Nth RUN edge):
      - Load z with the final RS value, including the bit produced that edge.
      - Set bout = ~(final carry).
      - Assert done; go to IDLE.
- done:
  - Registered and high for exactly one cycle after the Nth RUN edge.
  - busy is 0 in that same cycle.
- Latency: start accepted at edge k; done is high in the cycle after edge k+N.
  - Throughput is one operation per N+1 cycles.
- Back-to-back: a start asserted during the done cycle is accepted (FSM is already IDLE); done then deasserts as usual.
- start while busy: ignored; x and y are not resampled. Holding start high continuously restarts immediately on each IDLE.
- x and y may change freely after the accepted-start edge.
- z and bout change only on completion or reset, never during RUN.
- Arithmetic:
  - z = (x + (2^N − 1 − y) + 1) mod 2^N.
  - bout = 1 − carry_out.
  - Equal operands give z=0, bout=0.
- N=1 degenerate case: RUN lasts one edge; done is high in the cycle after edge k+1.

Test Plan:
- N=3; reset, then start with x=5, y=3 → busy high 3 cycles; done pulses in the cycle after edge k+3; z=3'b010, bout=0.
- x=3, y=5 → z=3'b110, bout=1. x=0, y=7 → z=3'b001, bout=1. x=7, y=7 → z=0, bout=0.
- Start accepted with x=6, y=1; change x=0, y=7 and pulse start during RUN → start ignored; result z=5, bout=0, single done.
- Assert start again in the done cycle (x=4, y=2) → second done 4 cycles later with z=2, bout=0; first result held in between.
- resetn=0 for one edge in the second RUN cycle → busy=0, z=0, bout=0, no done; next start with x=2, y=1 yields z=1.
- Exhaustive sweep of all 64 (x,y) pairs at N=3, plus a random N=8 run → z and bout match a reference model; every done is exactly one cycle wide.
